// File: rtl/cntry_car_sensor.sv
// Country-road vehicle queue and car-present sensor for the highway/country
// signal controller, with a sticky safety monitor on the light codes it sees.
module cntry_car_sensor #(
    parameter int         CNT_W       = 4,
    parameter int         PASS_CYCLES = 2,
    parameter logic [1:0] RED         = 2'd0,
    parameter logic [1:0] YELLOW      = 2'd1,
    parameter logic [1:0] GREEN       = 2'd2
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             arrive,
    input  logic [1:0]       hwy,
    input  logic [1:0]       cntry,
    output logic             X,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             depart,
    output logic             overflow,
    output logic             conflict,
    output logic             seq_err
);

    localparam int               TMR_W   = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [TMR_W-1:0] T_LAST  = TMR_W'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] Q_MAX   = '1;
    localparam logic [1:0]       ILLEGAL = 2'd3;

    typedef enum logic {
        S_WAIT,
        S_PASS
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] queue_nxt;
    logic             overflow_nxt;
    logic [1:0]       prev_hwy, prev_cntry;
    logic             green, queue_nz;
    logic             conflict_hit, seq_hit;

    // Only RED->GREEN->YELLOW->RED steps are allowed; holding a code is fine.
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        return (cur == prev)
            || (prev == RED    && cur == GREEN)
            || (prev == GREEN  && cur == YELLOW)
            || (prev == YELLOW && cur == RED);
    endfunction

    assign green    = (cntry == GREEN);
    assign queue_nz = (queue_cnt != '0);
    assign X        = queue_nz;

    // A car leaves only on the final timer count of an unbroken GREEN run.
    assign depart   = (state == S_PASS) && green && queue_nz && (timer == T_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        queue_nxt    = queue_cnt;
        overflow_nxt = overflow;
        case ({arrive, depart})
            2'b10: begin
                if (queue_cnt == Q_MAX) overflow_nxt = 1'b1;
                else                    queue_nxt    = queue_cnt + 1'b1;
            end
            2'b01:   queue_nxt = queue_cnt - 1'b1;
            default: queue_nxt = queue_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_WAIT: begin
                timer_nxt = '0;
                if (green && queue_nz) state_nxt = S_PASS;
            end
            S_PASS: begin
                if (!green || !queue_nz) begin
                    state_nxt = S_WAIT;
                    timer_nxt = '0;
                end else if (depart) begin
                    timer_nxt = '0;
                    state_nxt = (queue_nxt != '0) ? S_PASS : S_WAIT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = S_WAIT;
                timer_nxt = '0;
            end
        endcase
    end

    assign conflict_hit = (hwy == ILLEGAL) || (cntry == ILLEGAL)
                       || ((hwy != RED) && (cntry != RED));
    assign seq_hit      = !legal_step(prev_hwy, hwy) || !legal_step(prev_cntry, cntry);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= S_WAIT;
            timer      <= '0;
            queue_cnt  <= '0;
            overflow   <= 1'b0;
            conflict   <= 1'b0;
            seq_err    <= 1'b0;
            prev_hwy   <= GREEN;
            prev_cntry <= RED;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            queue_cnt  <= queue_nxt;
            overflow   <= overflow_nxt;
            conflict   <= conflict | conflict_hit;
            seq_err    <= seq_err | seq_hit;
            prev_hwy   <= hwy;
            prev_cntry <= cntry;
        end
    end

endmodule

// File: tb/tb_cntry_car_sensor.sv
// Directed bench for cntry_car_sensor: a vector table for queue fill and drain,
// plus hand sequences for full-queue, reset-in-flight and safety-flag cases.
module tb_cntry_car_sensor;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

    typedef struct {
        logic       arrive;
        logic [1:0] hwy;
        logic [1:0] cntry;
        logic       dep;
        logic [3:0] q;
        logic       ovf;
        logic       conf;
        logic       seq;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       arrive;
    logic [1:0] hwy, cntry;
    logic       X;
    logic [3:0] queue_cnt;
    logic       depart, overflow, conflict, seq_err;

    int total = 0;
    int bad   = 0;

    cntry_car_sensor #(.CNT_W(4), .PASS_CYCLES(2)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .arrive    (arrive),
        .hwy       (hwy),
        .cntry     (cntry),
        .X         (X),
        .queue_cnt (queue_cnt),
        .depart    (depart),
        .overflow  (overflow),
        .conflict  (conflict),
        .seq_err   (seq_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic [1:0] h, input logic [1:0] c,
                                input logic d, input logic [3:0] q,
                                input logic o, input logic cf, input logic s);
        vec_t v;
        v.arrive = a; v.hwy = h; v.cntry = c; v.dep = d;
        v.q = q; v.ovf = o; v.conf = cf; v.seq = s;
        return v;
    endfunction

    // Drive on negedge, check depart before the edge, check state after it.
    task automatic step(input vec_t v, input string name);
        @(negedge clock);
        arrive = v.arrive;
        hwy    = v.hwy;
        cntry  = v.cntry;
        #1;
        check({name, "_depart"}, depart, v.dep);
        @(posedge clock);
        #1;
        check({name, "_q"},    queue_cnt, v.q);
        check({name, "_x"},    X, (v.q != 0));
        check({name, "_ovf"},  overflow, v.ovf);
        check({name, "_conf"}, conflict, v.conf);
        check({name, "_seq"},  seq_err, v.seq);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_q"},      queue_cnt, 0);
        check({name, "_x"},      X, 0);
        check({name, "_depart"}, depart, 0);
        check({name, "_ovf"},    overflow, 0);
        check({name, "_conf"},   conflict, 0);
        check({name, "_seq"},    seq_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_n = 1'b0;
        arrive  = 1'b0;
        hwy     = G;
        cntry   = R;
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    vec_t vecs[$];

    initial begin
        // fill 3, clear highway, drain at one car per 2 GREEN clocks
        vecs.push_back(mk(1, G, R, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, G, R, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, G, R, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, Y, R, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, R, R, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 0, 0, 0, 0));
        // YELLOW interrupts a partial pass; timer must restart from zero
        vecs.push_back(mk(1, R, G, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, R, G, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, Y, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, R, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, R, G, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, R, Y, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, R, R, 0, 1, 0, 0, 0));

        clear_n = 1'b0;
        arrive  = 1'b0;
        hwy     = G;
        cntry   = R;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        clear_n = 1'b1;

        foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

        // fill to capacity, then overflow
        for (int k = 1; k <= 14; k++)
            step(mk(1, R, R, 0, 4'(1 + k), 0, 0, 0), $sformatf("fill%0d", k));
        step(mk(1, R, R, 0, 15, 1, 0, 0), "full_arrive");
        // arrival coinciding with departure keeps a full queue full
        step(mk(1, R, G, 0, 15, 1, 0, 0), "full_enter_pass");
        step(mk(1, R, G, 0, 15, 1, 0, 0), "full_timer");
        step(mk(1, R, G, 1, 15, 1, 0, 0), "full_arr_dep");
        step(mk(0, R, G, 0, 15, 1, 0, 0), "full_timer2");

        // asynchronous reset during the cycle a departure is pending
        @(negedge clock);
        arrive = 1'b0;
        #1;
        check("pend_depart", depart, 1);
        #2;
        clear_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clock);
        #1;
        check_all_zero("held_rst");
        @(negedge clock);
        hwy     = G;
        cntry   = R;
        @(negedge clock);
        clear_n = 1'b1;

        // legal sequences, then conflict alone, then an illegal step
        step(mk(0, G, R, 0, 0, 0, 0, 0), "s_a");
        step(mk(0, Y, R, 0, 0, 0, 0, 0), "s_b");
        step(mk(0, R, R, 0, 0, 0, 0, 0), "s_c");
        step(mk(0, R, G, 0, 0, 0, 0, 0), "s_d");
        step(mk(0, G, G, 0, 0, 0, 1, 0), "s_conf");
        step(mk(0, G, Y, 0, 0, 0, 1, 0), "s_hold1");
        step(mk(0, G, R, 0, 0, 0, 1, 0), "s_hold2");
        step(mk(0, G, Y, 0, 0, 0, 1, 1), "s_red_yel");

        // illegal code 3 trips both monitors
        do_reset();
        step(mk(1, 2'd3, R, 0, 1, 0, 1, 1), "s_code3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
